// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle CPU: word RAM plus LED and timer registers.
// Reads are combinational (zero latency); writes commit on the rising edge; no backpressure.
module dmem_mmio_responder #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [15:0] leds,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic [31:0]   r_mem [DEPTH];
    logic [15:0]   r_led;
    logic [31:0]   r_count;
    logic [31:0]   r_cmp;
    logic          r_match;
    logic          r_en;
    logic          r_ien;

    logic          w_ram_sel;
    logic [AW-1:0] w_idx;
    logic          w_wr_led;
    logic          w_wr_count;
    logic          w_wr_cmp;
    logic          w_wr_status;
    logic          w_hit;
    logic [31:0]   w_count_nxt;
    logic          w_match_nxt;

    assign w_ram_sel   = (aluout[31:AW+2] == '0);
    assign w_idx       = aluout[AW+1:2];
    assign w_wr_led    = memwrite && (aluout == A_LED);
    assign w_wr_count  = memwrite && (aluout == A_COUNT);
    assign w_wr_cmp    = memwrite && (aluout == A_CMP);
    assign w_wr_status = memwrite && (aluout == A_STATUS);
    assign w_hit       = r_en && (r_count == r_cmp);

    // CPU writes to COUNT beat the timer; a match event beats a W1C on MATCH.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_count)
            w_count_nxt = writedata;
        else if (w_hit)
            w_count_nxt = '0;
        else if (r_en)
            w_count_nxt = r_count + 32'd1;

        w_match_nxt = r_match;
        if (w_hit)
            w_match_nxt = 1'b1;
        else if (w_wr_status && writedata[0])
            w_match_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led   <= '0;
            r_count <= '0;
            r_cmp   <= '0;
            r_match <= 1'b0;
            r_en    <= 1'b0;
            r_ien   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_match <= w_match_nxt;
            if (w_wr_led)
                r_led <= writedata[15:0];
            if (w_wr_cmp)
                r_cmp <= writedata;
            if (w_wr_status) begin
                r_en  <= writedata[1];
                r_ien <= writedata[2];
            end
        end
    end

    // RAM keeps its contents through reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (reset && memwrite && w_ram_sel)
            r_mem[w_idx] <= writedata;
    end

    always_comb begin
        readdata = '0;
        if (w_ram_sel) begin
            readdata = r_mem[w_idx];
        end else begin
            case (aluout)
                A_LED:    readdata = {16'h0, r_led};
                A_COUNT:  readdata = r_count;
                A_CMP:    readdata = r_cmp;
                A_STATUS: readdata = {29'h0, r_ien, r_en, r_match};
                default:  readdata = '0;
            endcase
        end
    end

    assign leds = r_led;
    assign irq  = r_match & r_ien;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_mmio_responder;

    localparam int DEPTH = 64;
    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    wire  [31:0] readdata;
    wire  [15:0] leds;
    wire         irq;

    dmem_mmio_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Behavioural model of the visible state.
    logic [31:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    logic [15:0] m_led;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    bit          m_match;
    bit          m_en;
    bit          m_ien;

    function automatic bit is_ram(input logic [31:0] a);
        return a < DEPTH * 4;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (is_ram(a)) return m_mem[int'(a >> 2)];
        if (a == A_LED)    return {16'h0, m_led};
        if (a == A_COUNT)  return m_count;
        if (a == A_CMP)    return m_cmp;
        if (a == A_STATUS) return {29'h0, m_ien, m_en, m_match};
        return 32'h0;
    endfunction

    // Applies one rising edge of the rules to the model, using the inputs currently driven.
    task automatic model_edge();
        bit          fire;
        logic [31:0] cnt;
        bit          mt;
        if (!reset) begin
            m_led = 0; m_count = 0; m_cmp = 0; m_match = 0; m_en = 0; m_ien = 0;
            return;
        end
        fire = m_en && (m_count == m_cmp);
        cnt  = fire ? 32'h0 : (m_en ? m_count + 1 : m_count);
        mt   = m_match;
        if (memwrite && aluout == A_STATUS && writedata[0]) mt = 0;
        if (fire) mt = 1;
        if (memwrite) begin
            if (is_ram(aluout)) begin
                m_mem[int'(aluout >> 2)] = writedata;
                m_vld[int'(aluout >> 2)] = 1;
            end
            if (aluout == A_LED)   m_led = writedata[15:0];
            if (aluout == A_COUNT) cnt = writedata;
            if (aluout == A_CMP)   m_cmp = writedata;
            if (aluout == A_STATUS) begin
                m_en  = writedata[1];
                m_ien = writedata[2];
            end
        end
        m_count = cnt;
        m_match = mt;
    endtask

    task automatic drv(input logic rn, input logic we, input logic [31:0] a, input logic [31:0] d);
        reset = rn; memwrite = we; aluout = a; writedata = d;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drv(1'b1, 1'b1, a, d);
        edge_step();
    endtask

    task automatic test_reset();
        logic [31:0] regs [4] = '{A_LED, A_COUNT, A_CMP, A_STATUS};
        drv(1'b0, 1'b0, 32'h0, 32'h0);
        edge_step();
        edge_step();
        drv(1'b1, 1'b0, A_LED, 32'h0);
        n_run++;
        if (leds !== 16'h0) begin
            n_fail++; $display("FAIL reset_leds: got %h want 0000", leds);
        end
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b0, regs[i], 32'h0);
            n_run++;
            if (readdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg[%h]: got %h want 00000000", regs[i], readdata);
            end
            edge_step();
        end
    endtask

    task automatic test_ram();
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        drv(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        n_run++;
        if (readdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ram_rd_10: got %h want deadbeef", readdata);
        end
        drv(1'b1, 1'b0, 32'h0000_0013, 32'h0);
        n_run++;
        if (readdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ram_rd_13: got %h want deadbeef", readdata);
        end
        edge_step();
        wr(32'h0000_0014, 32'h0000_1234);
        drv(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        n_run++;
        if (readdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL ram_rd_14: got %h want 00001234", readdata);
        end
        drv(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        n_run++;
        if (readdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ram_rd_10_again: got %h want deadbeef", readdata);
        end
        edge_step();
    endtask

    task automatic test_mmio();
        wr(A_LED, 32'h0001_A5A5);
        drv(1'b1, 1'b0, A_LED, 32'h0);
        n_run++;
        if (leds !== 16'hA5A5) begin
            n_fail++; $display("FAIL led_pins: got %h want a5a5", leds);
        end
        n_run++;
        if (readdata !== 32'h0000_A5A5) begin
            n_fail++; $display("FAIL led_rd: got %h want 0000a5a5", readdata);
        end
        edge_step();
        wr(A_CMP, 32'h0000_0077);
        wr(32'hFFFF_0010, 32'hFFFF_FFFF);
        drv(1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
        n_run++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_rd: got %h want 00000000", readdata);
        end
        n_run++;
        if (leds !== 16'hA5A5) begin
            n_fail++; $display("FAIL unmapped_wr_leds: got %h want a5a5", leds);
        end
        drv(1'b1, 1'b0, A_CMP, 32'h0);
        n_run++;
        if (readdata !== 32'h0000_0077) begin
            n_fail++; $display("FAIL unmapped_wr_cmp: got %h want 00000077", readdata);
        end
        drv(1'b1, 1'b0, DEPTH * 4, 32'h0);
        n_run++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL ram_end_rd: got %h want 00000000", readdata);
        end
        edge_step();
    endtask

    task automatic test_timer();
        logic [31:0] exp_cnt [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic        exp_irq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        wr(A_CMP, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_STATUS, 32'h6);
        for (int i = 0; i < 9; i++) begin
            drv(1'b1, 1'b0, A_COUNT, 32'h0);
            n_run++;
            if (readdata !== exp_cnt[i]) begin
                n_fail++; $display("FAIL timer_count[%0d]: got %h want %h", i, readdata, exp_cnt[i]);
            end
            n_run++;
            if (irq !== exp_irq[i]) begin
                n_fail++; $display("FAIL timer_irq[%0d]: got %b want %b", i, irq, exp_irq[i]);
            end
            edge_step();
        end
    endtask

    task automatic wait_hit(input string tag);
        int budget = 20;
        while (!(m_en && m_count == m_cmp) && budget > 0) begin
            drv(1'b1, 1'b0, A_COUNT, 32'h0);
            edge_step();
            budget--;
        end
        if (budget == 0) begin
            n_run++; n_fail++;
            $display("FAIL %s: no match cycle within budget, count %h", tag, m_count);
        end
    endtask

    task automatic test_collision();
        wait_hit("w1c_wait");
        wr(A_STATUS, 32'h7);
        drv(1'b1, 1'b0, A_STATUS, 32'h0);
        n_run++;
        if (readdata !== 32'h7) begin
            n_fail++; $display("FAIL w1c_on_match: got %h want 00000007", readdata);
        end
        edge_step();
        wr(A_STATUS, 32'h7);
        drv(1'b1, 1'b0, A_STATUS, 32'h0);
        n_run++;
        if (readdata !== 32'h6) begin
            n_fail++; $display("FAIL w1c_clear: got %h want 00000006", readdata);
        end
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL w1c_irq: got %b want 0", irq);
        end
        edge_step();
        wait_hit("reload_wait");
        wr(A_COUNT, 32'h10);
        drv(1'b1, 1'b0, A_COUNT, 32'h0);
        n_run++;
        if (readdata !== 32'h10) begin
            n_fail++; $display("FAIL count_wr_on_reload: got %h want 00000010", readdata);
        end
        edge_step();
        wr(A_STATUS, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        logic        irq_a [3] = '{0, 0, 1};
        logic [31:0] exp_b [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
        wr(A_STATUS, 32'h1);
        wr(A_CMP, 32'hFFFF_FFFF);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_STATUS, 32'h7);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, A_COUNT, 32'h0);
            n_run++;
            if (readdata !== exp_a[i] || irq !== irq_a[i]) begin
                n_fail++;
                $display("FAIL wrap_match[%0d]: got count %h irq %b want %h irq %b", i, readdata, irq, exp_a[i], irq_a[i]);
            end
            edge_step();
        end
        wr(A_STATUS, 32'h1);
        wr(A_CMP, 32'd5);
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_STATUS, 32'h7);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, A_COUNT, 32'h0);
            n_run++;
            if (readdata !== exp_b[i] || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_nomatch[%0d]: got count %h irq %b want %h irq 0", i, readdata, irq, exp_b[i]);
            end
            edge_step();
        end
        wr(A_STATUS, 32'h0);
    endtask

    task automatic test_reset_mid();
        wr(32'h0000_0020, 32'hCAFE_F00D);
        wr(A_LED, 32'h0000_FFFF);
        wr(A_CMP, 32'd2);
        wr(A_COUNT, 32'd0);
        wr(A_STATUS, 32'h7);
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b0, A_COUNT, 32'h0);
            edge_step();
        end
        drv(1'b1, 1'b0, A_COUNT, 32'h0);
        n_run++;
        if (leds !== 16'hFFFF || irq !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got leds %h irq %b want ffff 1", leds, irq);
        end
        drv(1'b0, 1'b1, A_LED, 32'h0000_1234);
        edge_step();
        drv(1'b1, 1'b0, A_COUNT, 32'h0);
        n_run++;
        if (leds !== 16'h0 || irq !== 1'b0 || readdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset: got leds %h irq %b count %h want 0000 0 00000000", leds, irq, readdata);
        end
        edge_step();
        drv(1'b1, 1'b0, A_COUNT, 32'h0);
        n_run++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_timer_stopped: got %h want 00000000", readdata);
        end
        drv(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        n_run++;
        if (readdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL reset_ram_20: got %h want cafef00d", readdata);
        end
        drv(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        n_run++;
        if (readdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL reset_ram_10: got %h want deadbeef", readdata);
        end
        edge_step();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        rn;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = {$urandom_range(0, DEPTH - 1), 2'($urandom_range(0, 3))};
                2:       a = A_LED;
                3:       a = A_COUNT;
                4:       a = A_CMP;
                5:       a = A_STATUS;
                6:       a = 32'hFFFF_0010 + 32'($urandom_range(0, 3) * 4);
                default: a = $urandom | 32'h8000_0000;
            endcase
            d = $urandom;
            if (a == A_CMP || a == A_COUNT) d = $urandom_range(0, 12);
            if (a == A_STATUS) d = $urandom_range(0, 7);
            we = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 99) != 0);
            drv(rn, we, a, d);
            if (!(is_ram(a) && !m_vld[int'(a >> 2)])) begin
                n_run++;
                if (readdata !== model_rd(a)) begin
                    n_fail++; $display("FAIL rand_rd[%0d] @%h: got %h want %h", n, a, readdata, model_rd(a));
                end
            end
            n_run++;
            if (leds !== m_led || irq !== (m_match & m_ien)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got leds %h irq %b want %h %b", n, leds, irq, m_led, m_match & m_ien);
            end
            edge_step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d tests run", n_run);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        test_reset();
        test_ram();
        test_mmio();
        test_timer();
        test_collision();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving the number of 32-bit RAM words (power of two, 16..1024).
REQ-002 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port memwrite  input  1  write strobe from the CPU data port; one write per cycle while high.
REQ-005 SHALL have port aluout  input  32  byte address from the CPU data port.
REQ-006 SHALL have port writedata  input  32  store data from the CPU.
REQ-007 SHALL have port readdata  output  32  load data returned to the CPU in the same cycle.
REQ-008 SHALL have port leds  output  16  the LED register value.
REQ-009 SHALL have port irq  output  1  timer interrupt request, level-sensitive.

Function
REQ-010 SHALL decode RAM at 0x0000_0000 to DEPTH*4-1; word index = aluout[log2(DEPTH)+1:2]; aluout[1:0] ignored.
REQ-011 SHALL decode MMIO registers: LED 0xFFFF_0000, COUNT 0xFFFF_0004, CMP 0xFFFF_0008, STATUS 0xFFFF_000C.
REQ-012 SHALL return readdata = 0 for any unmapped address and SHALL ignore writes to it.
REQ-013 SHALL drive readdata combinationally from the current aluout (zero-cycle read latency), as needed by a single-cycle CPU.
REQ-014 SHALL perform RAM and register writes at the rising edge when memwrite=1; read-after-write to the same address returns new data from the next cycle on.
REQ-015 LED: R/W; writes store writedata[15:0]; reads return {16'h0, led}; leds = led.
REQ-016 COUNT: R/W 32-bit timer; a write loads writedata.
REQ-017 CMP: R/W 32-bit compare value.
REQ-018 STATUS: bit0 MATCH (read, write-1-to-clear), bit1 EN (R/W), bit2 IEN (R/W); bits 31:3 read 0 and ignore writes.
REQ-019 When EN=1 and COUNT != CMP, COUNT SHALL increment by 1 per cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-020 When EN=1 and COUNT == CMP, next edge SHALL set COUNT to 0 (auto-reload) and set MATCH to 1.
REQ-021 When EN=0, COUNT SHALL hold and MATCH SHALL not be set.
REQ-022 A CPU write to COUNT in the same cycle as an increment or reload SHALL take priority (COUNT = writedata).
REQ-023 A MATCH set and a W1C clear in the same cycle SHALL leave MATCH = 1.
REQ-024 A STATUS write SHALL update EN and IEN in the same edge as any W1C on MATCH; a new EN value takes effect on the following cycle.
REQ-025 irq SHALL equal MATCH & IEN, registered-state only (no combinational path from the inputs).
REQ-026 Period between MATCH events with EN=1 and no COUNT writes SHALL be CMP+1 cycles.

Reset
REQ-027 On a rising edge with reset=0: LED, COUNT, CMP, MATCH, EN and IEN SHALL become 0, so leds=0 and irq=0 on the next cycle.
REQ-028 Reset SHALL take priority over any simultaneous memwrite or timer event.
REQ-029 RAM contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-030 Reset asserted mid-count SHALL stop the timer (EN=0, COUNT=0) immediately at that edge.

Verification
REQ-031 RAM: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEAD_BEEF; read 0x0000_0014 after writing 0x1234 there -> 0x0000_1234.
REQ-032 MMIO/unmapped: write 0x0001_A5A5 to LED -> leds=0xA5A5, readback 0x0000_A5A5; write to 0xFFFF_0010 -> no state change, read returns 0.
REQ-033 Timer: CMP=3, STATUS=0x6 (EN, IEN) -> COUNT sequence 0,1,2,3,0; MATCH and irq rise 4 cycles after EN takes effect; repeat every 4 cycles.
REQ-034 Collisions: W1C on MATCH in the cycle COUNT==CMP -> MATCH stays 1; write COUNT=0x10 in a reload cycle -> COUNT=0x10 next cycle.
REQ-035 Wrap: CMP=0xFFFF_FFFF, COUNT=0xFFFF_FFFE, EN=1 -> FFFF_FFFF, then 0 with MATCH=1; with CMP=5 and COUNT=0xFFFF_FFFF -> 0 with no MATCH.
REQ-036 Reset: drive reset=0 for one edge with timer running and LED=0xFFFF -> leds=0, irq=0, COUNT readback 0, earlier RAM data still readable.
